alu_arbiter: RTL and testbench

Sequencing controller and two-port arbiter for the shared 32-bit structural ALU datapath (ripple adder, xor/nand/nor arrays). Accepts operation requests from two requesters with valid/ready handshakes and grants the ALU round-robin. Decodes the 3-bit command into datapath controls, holds operands stable for a fixed number of settle cycles to cover gate-delay ripple, then captures the result and flags into a registered response.

---
 rtl/alu_arbiter_pkg.sv | 43 ++++
 rtl/alu_cmd_decode.sv | 39 +++
 rtl/alu_arbiter.sv | 179 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for users of the 32-bit structural ALU datapath:
//   - operand width
//   - 3-bit command codes (cADD..cOR)
//   - datapath result-select (muxindex) encodings
//   - arbiter FSM state encoding
//   - helper telling which commands report carry/overflow
package alu_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    cADD  = 3'd0,
    cSUB  = 3'd1,
    cXOR  = 3'd2,
    cSLT  = 3'd3,
    cAND  = 3'd4,
    cNAND = 3'd5,
    cNOR  = 3'd6,
    cOR   = 3'd7
  } alu_cmd_e;

  // Result-select inputs of the datapath output mux.
  localparam logic [2:0] MUX_SUM  = 3'd0;
  localparam logic [2:0] MUX_XOR  = 3'd1;
  localparam logic [2:0] MUX_AND  = 3'd2;
  localparam logic [2:0] MUX_NAND = 3'd3;
  localparam logic [2:0] MUX_NOR  = 3'd4;
  localparam logic [2:0] MUX_OR   = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Only true add/subtract report the adder's carry and overflow.
  // SLT uses the adder internally but returns a boolean, so its flags are 0.
  function automatic logic cmd_has_flags(input alu_cmd_e cmd);
    return (cmd == cADD) || (cmd == cSUB);
  endfunction

endpackage

// File: rtl/alu_cmd_decode.sv
// alu_cmd_decode
// Combinational decoder from a 3-bit ALU command to the datapath controls.
// Ports:
//   cmd       in  3  command code (alu_cmd_e encoding)
//   muxindex  out 3  datapath result select
//   inverse   out 1  invert operand b before the adder
//   carryin   out 1  adder carry-in
module alu_cmd_decode
  import alu_arbiter_pkg::*;
(
  input  logic [2:0] cmd,
  output logic [2:0] muxindex,
  output logic       inverse,
  output logic       carryin
);

  always_comb begin
    muxindex = MUX_SUM;
    inverse  = 1'b0;
    carryin  = 1'b0;
    case (cmd)
      cADD:  muxindex = MUX_SUM;
      // a + ~b + 1 = a - b; SLT reads the sign of that difference.
      cSUB,
      cSLT: begin
        muxindex = MUX_SUM;
        inverse  = 1'b1;
        carryin  = 1'b1;
      end
      cXOR:  muxindex = MUX_XOR;
      cAND:  muxindex = MUX_AND;
      cNAND: muxindex = MUX_NAND;
      cNOR:  muxindex = MUX_NOR;
      cOR:   muxindex = MUX_OR;
      default: muxindex = MUX_SUM;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-port round-robin arbiter and sequencer for the shared structural ALU.
// A granted request is latched onto registered alu_* outputs, held for
// SETTLE_CYCLES cycles so the ripple datapath settles, then the result and
// flags are captured into a registered response held until resp_ready.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid[1:0] / req_ready[1:0]  request handshakes, bit i = requester i
//   req_cmd0/1, req_a0/1, req_b0/1   per-requester command and operands
//   resp_valid / resp_ready          response handshake
//   resp_id, resp_result             owner of the response, 32-bit result
//   resp_zero, resp_carry, resp_ovf  result flags
//   alu_a, alu_b, alu_muxindex,
//   alu_inverse, alu_carryin         registered controls to the datapath
//   alu_res, alu_carryout,
//   alu_overflow                     datapath outputs
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req_cmd0,
  input  logic [2:0]        req_cmd1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_carry,
  output logic              resp_ovf,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_muxindex,
  output logic              alu_inverse,
  output logic              alu_carryin,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_carryout,
  input  logic              alu_overflow
);

  // The counter is loaded at accept and the capture happens on the cycle it
  // reads zero, so EXEC lasts exactly SETTLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ptr_reg;   // requester favored when both are valid
  logic              id_reg;    // owner of the operation in flight
  alu_cmd_e          cmd_reg;

  logic              grant;
  logic              accept;
  logic [2:0]        cmd_arr [2];
  logic [DATA_W-1:0] a_arr   [2];
  logic [DATA_W-1:0] b_arr   [2];
  logic [2:0]        sel_cmd;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  logic [2:0]        dec_muxindex;
  logic              dec_inverse;
  logic              dec_carryin;

  logic              slt_bit;
  logic [DATA_W-1:0] final_result;

  assign cmd_arr[0] = req_cmd0;
  assign cmd_arr[1] = req_cmd1;
  assign a_arr[0]   = req_a0;
  assign a_arr[1]   = req_a1;
  assign b_arr[0]   = req_b0;
  assign b_arr[1]   = req_b1;

  // With a single requester valid it wins outright; with both valid the
  // pointer breaks the tie. With none valid grant is a don't-care.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant = ptr_reg;
    end else begin
      grant = req_valid[1];
    end
  end

  // Ready is offered only to the granted requester, only in IDLE, and never
  // while reset is asserted, so at most one bit can be high.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && (state_reg == IDLE) &&
                             req_valid[gi] && (grant == 1'(gi));
    end
  endgenerate

  assign accept  = |req_ready;
  assign sel_cmd = cmd_arr[grant];
  assign sel_a   = a_arr[grant];
  assign sel_b   = b_arr[grant];

  alu_cmd_decode u_decode (
    .cmd      (sel_cmd),
    .muxindex (dec_muxindex),
    .inverse  (dec_inverse),
    .carryin  (dec_carryin)
  );

  // SLT: a - b is negative when the difference's sign disagrees with overflow.
  assign slt_bit      = alu_res[DATA_W-1] ^ alu_overflow;
  assign final_result = (cmd_reg == cSLT) ? {{(DATA_W-1){1'b0}}, slt_bit}
                                          : alu_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ptr_reg      <= 1'b0;
      id_reg       <= 1'b0;
      cmd_reg      <= cADD;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_result  <= '0;
      resp_zero    <= 1'b0;
      resp_carry   <= 1'b0;
      resp_ovf     <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_muxindex <= MUX_SUM;
      alu_inverse  <= 1'b0;
      alu_carryin  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            // Operands and controls stay frozen from here until the next
            // accept, keeping the datapath inputs constant through EXEC.
            alu_a        <= sel_a;
            alu_b        <= sel_b;
            alu_muxindex <= dec_muxindex;
            alu_inverse  <= dec_inverse;
            alu_carryin  <= dec_carryin;
            cmd_reg      <= alu_cmd_e'(sel_cmd);
            id_reg       <= grant;
            cnt_reg      <= CNT_LOAD;
            state_reg    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_reg == '0) begin
            resp_valid  <= 1'b1;
            resp_id     <= id_reg;
            resp_result <= final_result;
            resp_zero   <= (final_result == '0);
            resp_carry  <= cmd_has_flags(cmd_reg) ? alu_carryout : 1'b0;
            resp_ovf    <= cmd_has_flags(cmd_reg) ? alu_overflow : 1'b0;
            state_reg   <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            ptr_reg    <= ~id_reg;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioral model of the
// structural ALU datapath attached to the alu_* ports.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_cmd0, req_cmd1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic        resp_zero, resp_carry, resp_ovf;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_muxindex;
  logic        alu_inverse, alu_carryin;
  logic [31:0] alu_res;
  logic        alu_carryout, alu_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_carry(resp_carry), .resp_ovf(resp_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_muxindex(alu_muxindex),
    .alu_inverse(alu_inverse), .alu_carryin(alu_carryin),
    .alu_res(alu_res), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow)
  );

  // Behavioral stand-in for the ripple adder and logic arrays.
  logic [31:0] b_eff;
  logic [32:0] sum;
  always_comb begin
    b_eff        = alu_inverse ? ~alu_b : alu_b;
    sum          = {1'b0, alu_a} + {1'b0, b_eff} + {32'b0, alu_carryin};
    alu_carryout = sum[32];
    alu_overflow = (alu_a[31] == b_eff[31]) && (sum[31] != alu_a[31]);
    case (alu_muxindex)
      3'd0:    alu_res = sum[31:0];
      3'd1:    alu_res = alu_a ^ alu_b;
      3'd2:    alu_res = alu_a & alu_b;
      3'd3:    alu_res = ~(alu_a & alu_b);
      3'd4:    alu_res = ~(alu_a | alu_b);
      3'd5:    alu_res = alu_a | alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
    req_cmd0 = 3'd0; req_cmd1 = 3'd0;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [2:0] cmd,
                         input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      req_cmd0 = cmd; req_a0 = a; req_b0 = b;
    end else begin
      req_cmd1 = cmd; req_a1 = a; req_b1 = b;
    end
    req_valid[r] = 1'b1;
  endtask

  // Drives one request, waits for accept, then counts edges until resp_valid.
  task automatic run_op(input int r, input logic [2:0] cmd,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int w = 0;
    lat = -1;
    set_req(r, cmd, a, b);
    #1;
    while (!req_ready[r] && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!req_ready[r]) begin
      errors++;
      $display("FAIL accept_timeout r=%0d req_ready=%b required bit %0d high", r, req_ready, r);
      req_valid[r] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("op r=%0d cmd=%0d a=%h b=%h -> id=%0d result=%h z=%0b c=%0b v=%0b lat=%0d",
             r, cmd, a, b, resp_id, resp_result, resp_zero, resp_carry, resp_ovf, lat);
  endtask

  task automatic ack_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if ({resp_id, resp_zero, resp_carry, resp_ovf} !== 4'b0) begin errors++; $display("FAIL rst_resp_flags got=%b exp=0000", {resp_id, resp_zero, resp_carry, resp_ovf}); end
    checks++; if (resp_result !== 32'h0) begin errors++; $display("FAIL rst_resp_result got=%h exp=0", resp_result); end
    checks++; if ({alu_a, alu_b} !== 64'h0) begin errors++; $display("FAIL rst_alu_ops got=%h/%h exp=0/0", alu_a, alu_b); end
    checks++; if ({alu_muxindex, alu_inverse, alu_carryin} !== 5'b0) begin errors++; $display("FAIL rst_alu_ctrl got=%b exp=00000", {alu_muxindex, alu_inverse, alu_carryin}); end
    $display("reset checked");
  endtask

  task automatic test_sub();
    int lat;
    run_op(0, 3'd1, 32'h0000_0802, 32'h0000_0001, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency got=%0d exp=4", lat); end
    checks++; if (resp_result !== 32'h0000_0801) begin errors++; $display("FAIL sub_result got=%h exp=00000801", resp_result); end
    checks++; if ({resp_carry, resp_ovf, resp_zero, resp_id} !== 4'b1000) begin errors++; $display("FAIL sub_flags c,v,z,id got=%b exp=1000", {resp_carry, resp_ovf, resp_zero, resp_id}); end
    ack_resp();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sub_resp_drop got=%b exp=0", resp_valid); end
  endtask

  task automatic test_add_slt();
    int lat;
    run_op(1, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    checks++; if (resp_result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got=%h exp=80000000", resp_result); end
    checks++; if ({resp_carry, resp_ovf, resp_zero, resp_id} !== 4'b0101) begin errors++; $display("FAIL add_flags c,v,z,id got=%b exp=0101", {resp_carry, resp_ovf, resp_zero, resp_id}); end
    ack_resp();
    run_op(1, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    checks++; if (resp_result !== 32'h0000_0001) begin errors++; $display("FAIL slt_result got=%h exp=00000001", resp_result); end
    checks++; if ({resp_carry, resp_ovf, resp_zero} !== 3'b000) begin errors++; $display("FAIL slt_flags c,v,z got=%b exp=000", {resp_carry, resp_ovf, resp_zero}); end
    ack_resp();
  endtask

  task automatic test_xor_exec();
    int w = 0;
    set_req(0, 3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    #1;
    while (!req_ready[0] && w < 20) begin @(negedge clk); w++; end
    checks++; if (!req_ready[0]) begin errors++; $display("FAIL xor_accept got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    checks++; if ({alu_muxindex, alu_inverse} !== 4'b0010) begin errors++; $display("FAIL xor_exec_ctrl mux,inv got=%b exp=0010", {alu_muxindex, alu_inverse}); end
    checks++; if (alu_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL xor_exec_a got=%h exp=deadbeef", alu_a); end
    repeat (2) @(negedge clk);
    checks++; if ({resp_valid, alu_muxindex, alu_inverse} !== 5'b00010) begin errors++; $display("FAIL xor_exec_hold v,mux,inv got=%b exp=00010", {resp_valid, alu_muxindex, alu_inverse}); end
    w = 0;
    while (!resp_valid && w < 20) begin @(negedge clk); w++; end
    $display("op r=0 cmd=2 a=deadbeef b=deadbeef -> id=%0d result=%h z=%0b", resp_id, resp_result, resp_zero);
    checks++; if ({resp_valid, resp_zero} !== 2'b11 || resp_result !== 32'h0) begin errors++; $display("FAIL xor_result v,z=%b result=%h exp v,z=11 result=0", {resp_valid, resp_zero}, resp_result); end
    ack_resp();
  endtask

  task automatic test_backpressure();
    int lat;
    int w = 0;
    run_op(0, 3'd4, 32'h1234_5678, 32'h0000_FFFF, lat);
    set_req(1, 3'd6, 32'hFFFF_0000, 32'h0000_FFFF);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_result !== 32'h0000_5678) begin errors++; $display("FAIL bp_hold cyc=%0d v=%b result=%h exp v=1 result=00005678", i, resp_valid, resp_result); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_no_accept cyc=%0d req_ready=%b exp=00", i, req_ready); end
    end
    ack_resp();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_pending_grant req_ready=%b exp=10", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    while (!resp_valid && w < 20) begin @(negedge clk); w++; end
    $display("op r=1 cmd=6 a=ffff0000 b=0000ffff -> id=%0d result=%h z=%0b", resp_id, resp_result, resp_zero);
    checks++; if (resp_result !== 32'h0 || {resp_zero, resp_id} !== 2'b11) begin errors++; $display("FAIL bp_pending_result result=%h z,id=%b exp result=0 z,id=11", resp_result, {resp_zero, resp_id}); end
    ack_resp();
  endtask

  task automatic test_back_to_back();
    int gseq[6];
    int gcyc[6];
    int cnt[2];
    bit drop[2];
    int ng = 0;
    int nr = 0;
    int onehot_bad = 0;
    int spacing_bad = 0;
    logic [31:0] exp_res;
    for (int i = 0; i < 6; i++) begin gseq[i] = -1; gcyc[i] = 0; end
    cnt[0] = 0; cnt[1] = 0; drop[0] = 0; drop[1] = 0;
    do_reset();
    set_req(0, 3'd0, 32'd5, 32'd3);
    set_req(1, 3'd7, 32'h0000_00F0, 32'h0000_000F);
    resp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 80 && (ng < 6 || nr < 6); cyc++) begin
      if (req_ready == 2'b11) onehot_bad++;
      if (resp_valid) begin
        exp_res = (nr % 2 == 0) ? 32'd8 : 32'h0000_00FF;
        $display("b2b resp n=%0d id=%0d result=%h", nr, resp_id, resp_result);
        checks++; if (resp_id !== 1'((nr % 2)) || resp_result !== exp_res) begin errors++; $display("FAIL b2b_resp n=%0d id=%0d result=%h exp id=%0d result=%h", nr, resp_id, resp_result, nr % 2, exp_res); end
        nr++;
      end
      if (req_ready != 2'b00 && ng < 6) begin
        gseq[ng] = req_ready[1] ? 1 : 0;
        gcyc[ng] = cyc;
        cnt[gseq[ng]]++;
        if (cnt[gseq[ng]] == 3) drop[gseq[ng]] = 1'b1;
        ng++;
      end
      @(negedge clk);
      for (int r = 0; r < 2; r++) if (drop[r]) req_valid[r] = 1'b0;
    end
    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (gseq[i] != i % 2) begin errors++; $display("FAIL b2b_grant n=%0d got=%0d exp=%0d", i, gseq[i], i % 2); end
    end
    for (int i = 1; i < 6; i++) if (gcyc[i] - gcyc[i-1] != 6) spacing_bad++;
    checks++; if (spacing_bad != 0) begin errors++; $display("FAIL b2b_spacing bad_gaps=%0d exp=0 (6 cycles per op)", spacing_bad); end
    checks++; if (onehot_bad != 0) begin errors++; $display("FAIL b2b_onehot cycles_with_two_ready=%0d exp=0", onehot_bad); end
    checks++; if (nr != 6) begin errors++; $display("FAIL b2b_resp_count got=%0d exp=6", nr); end
  endtask

  task automatic test_reset_mid_exec();
    int w = 0;
    int late_resp = 0;
    int lat;
    set_req(0, 3'd1, 32'h0000_0100, 32'h0000_0010);
    #1;
    while (!req_ready[0] && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({resp_valid, req_ready} !== 3'b000) begin errors++; $display("FAIL midrst_handshake v,ready got=%b exp=000", {resp_valid, req_ready}); end
    checks++; if ({alu_a, alu_b} !== 64'h0) begin errors++; $display("FAIL midrst_alu_ops got=%h/%h exp=0/0", alu_a, alu_b); end
    checks++; if ({alu_muxindex, alu_inverse, alu_carryin} !== 5'b0) begin errors++; $display("FAIL midrst_alu_ctrl got=%b exp=00000", {alu_muxindex, alu_inverse, alu_carryin}); end
    checks++; if (resp_result !== 32'h0 || {resp_id, resp_zero, resp_carry, resp_ovf} !== 4'b0) begin errors++; $display("FAIL midrst_resp result=%h id,z,c,v=%b exp 0/0000", resp_result, {resp_id, resp_zero, resp_carry, resp_ovf}); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) late_resp++;
    end
    checks++; if (late_resp != 0) begin errors++; $display("FAIL midrst_discard resp_valid_cycles=%0d exp=0", late_resp); end
    run_op(1, 3'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_fresh_latency got=%0d exp=4", lat); end
    checks++; if (resp_result !== 32'hF0FF_F0FF || {resp_id, resp_zero, resp_carry, resp_ovf} !== 4'b1000) begin errors++; $display("FAIL midrst_fresh_result result=%h id,z,c,v=%b exp f0fff0ff/1000", resp_result, {resp_id, resp_zero, resp_carry, resp_ovf}); end
    ack_resp();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add_slt();
    test_xor_exec();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
